seq_mul_unit: RTL and testbench

SEQ_MUL_UNIT -- requirements
Module: seq_mul_unit

---
 rtl/seq_mul_unit.sv | 76 +++++++
 tb/tb_seq_mul_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: 32-cycle shift-and-add multiplier, signed/unsigned, with pipeline stall, flush and done pulse.
module seq_mul_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sign,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t         state_q;
    logic [5:0]     cnt_q;
    logic [2*W:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, abs_a, abs_b, hi_q, lo_q;
    logic           neg_q, done_q;
    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    always_comb begin
        abs_a = (sign && a[W-1]) ? -a : a;
        abs_b = (sign && b[W-1]) ? -b : b;
        sum   = acc_q[2*W:W] + {1'b0, {W{acc_q[0]}} & mcand_q};
        acc_d = {1'b0, sum, acc_q[W-1:1]};
        prod  = neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) state_q <= IDLE;
            else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q <= RUN;
                        mcand_q <= abs_a;
                        acc_q   <= {{(W+1){1'b0}}, abs_b};
                        cnt_q   <= '0;
                        neg_q   <= sign & (a[W-1] ^ b[W-1]);
                    end
                    RUN: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(W-1)) state_q <= FIN;
                    end
                    FIN: begin
                        {hi_q, lo_q} <= prod;
                        done_q       <= 1'b1;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    // reset forces the state to IDLE, so stall only reflects the request
    assign busy  = state_q != IDLE;
    assign stall = reset ? start : (busy | (start & (state_q == IDLE)));
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed vectors for seq_mul_unit with hand-computed products and latency checks.
module tb_seq_mul_unit;
    logic        clk = 1'b0, reset, start, sign, flush;
    logic [31:0] a, b, hi, lo;
    logic        busy, stall, done;
    int          total = 0, bad = 0;
    seq_mul_unit #(.W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .sign(sign), .a(a), .b(b),
        .flush(flush), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Starts an op at posedge+1 and returns in its done cycle; poke pulses start mid-run.
    task automatic do_op(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic poke);
        int n, busy_n;
        start = 1'b1; sign = s; a = x; b = y;
        #1 chk({tag, "_stall_req"}, stall, 1);
        @(posedge clk); #1;
        start = 1'b0; sign = ~s; a = 32'h1234_5678; b = 32'h9abc_def0;
        n = 0; busy_n = 0;
        while (!done && n < 40) begin
            busy_n += int'(busy);
            start = poke && (n == 5 || n == 20);
            #1;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_busy_cycles"}, busy_n, 33);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_stall_at_done"}, stall, 0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask
    task automatic no_done(input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        chk(tag, seen, 0);
    endtask
    initial begin
        reset = 1'b1; start = 1'b1; sign = 1'b0; flush = 1'b0; a = '0; b = '0;
        #1 chk("stall_in_reset", stall, 1);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_stall", stall, 0);
        do_op("umax", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        @(posedge clk); #1 chk("done_one_cycle", done, 0);
        chk("hilo_hold_idle", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("smin_sq", 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        do_op("sneg1", 1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("s_m7x6", 1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
        do_op("u_m7x6", 0, 32'hFFFF_FFF9, 32'h0000_0006, 32'h0000_0005, 32'hFFFF_FFD6, 0);
        do_op("s_5xm3", 1, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        do_op("zero", 0, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0, 32'h0, 0);
        do_op("prior", 0, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000, 0);
        // flush at iteration 10: old product stays, no completion
        start = 1'b1; sign = 1'b0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_stall", stall, 0);
        no_done("flush_no_done", 40);
        chk("flush_hilo", {hi, lo}, 64'h0000_0003_0000_0000);
        do_op("after_flush", 0, 32'd3, 32'd5, 32'd0, 32'd15, 0);
        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd9;
        #1 chk("fs_stall", stall, 1);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("fs_busy", busy, 0);
        no_done("fs_no_done", 36);
        chk("fs_hilo", {hi, lo}, 64'd15);
        // back-to-back: second start lands in the first op's done cycle
        do_op("b2b_first", 0, 32'd2, 32'd3, 32'd0, 32'd6, 0);
        do_op("b2b_second", 0, 32'd4, 32'd5, 32'd0, 32'd20, 1);
        @(posedge clk); #1 chk("b2b_no_extra", {busy, done}, 2'b00);
        // reset at iteration 20
        start = 1'b1; sign = 1'b1; a = 32'hFFFF_FFF9; b = 32'd6;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_hilo", {hi, lo}, 64'h0);
        chk("mrst_stall", stall, 0);
        no_done("mrst_no_done", 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
